// File: rtl/exe_pkg.sv
// Shared types for the execution command queue: opcodes, controller states
// and the width of the status flags returned by the execution unit.
package exe_pkg;

    localparam int STATUS_W = 4;

    typedef enum logic [1:0] {
        SUB = 2'b00,
        CMP = 2'b01,
        SHF = 2'b10,
        BIT = 2'b11
    } exe_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        DRIVE = 2'b01,
        HOLD  = 2'b10
    } exe_state_e;

endpackage

// File: rtl/exe_cmd_fifo.sv
// Command FIFO holding {a, b, op} tuples; power-of-two depth so the pointers
// wrap by plain overflow.
module exe_cmd_fifo
    import exe_pkg::*;
#(
    parameter int BITS  = 8,
    parameter int DEPTH = 4
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_push,
    input  logic [BITS-1:0]              i_a,
    input  logic [BITS-1:0]              i_b,
    input  logic [1:0]                   i_op,
    input  logic                         i_pop,
    output logic [BITS-1:0]              o_a,
    output logic [BITS-1:0]              o_b,
    output logic [1:0]                   o_op,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_ready
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [BITS-1:0]  mem_a_q  [DEPTH];
    logic [BITS-1:0]  mem_a_d  [DEPTH];
    logic [BITS-1:0]  mem_b_q  [DEPTH];
    logic [BITS-1:0]  mem_b_d  [DEPTH];
    exe_op_e          mem_op_q [DEPTH];
    exe_op_e          mem_op_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    // Pushes are gated by the registered fullness, so a full queue ignores i_push.
    always_comb begin
        mem_a_d  = mem_a_q;
        mem_b_d  = mem_b_q;
        mem_op_d = mem_op_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_push  = i_push && (count_q < FULL_COUNT);
        do_pop   = i_pop && (count_q != '0);

        if (do_push) begin
            mem_a_d[wr_ptr_q]  = i_a;
            mem_b_d[wr_ptr_q]  = i_b;
            mem_op_d[wr_ptr_q] = exe_op_e'(i_op);
            wr_ptr_d           = wr_ptr_q + PTR_W'(1);
        end

        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_a_q[i]  <= '0;
                mem_b_q[i]  <= '0;
                mem_op_q[i] <= SUB;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_a_q  <= mem_a_d;
            mem_b_q  <= mem_b_d;
            mem_op_q <= mem_op_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign o_a     = mem_a_q[rd_ptr_q];
    assign o_b     = mem_b_q[rd_ptr_q];
    assign o_op    = mem_op_q[rd_ptr_q];
    assign o_count = count_q;
    assign o_ready = (count_q < FULL_COUNT);

endmodule

// File: rtl/exe_cmd_queue.sv
// Queues commands for exe_unit_w6, issues one at a time, waits LAT clocks for
// the unit's answer and holds the captured result until it is accepted.
module exe_cmd_queue
    import exe_pkg::*;
#(
    parameter int BITS  = 8,
    parameter int DEPTH = 4,
    parameter int LAT   = 1
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic [BITS-1:0]              in_a,
    input  logic [BITS-1:0]              in_b,
    input  logic [1:0]                   i_op,
    input  logic                         i_valid,
    output logic                         o_ready,
    output logic [BITS-1:0]              o_a,
    output logic [BITS-1:0]              o_b,
    output logic [1:0]                   o_op,
    input  logic [BITS-1:0]              i_res,
    input  logic [STATUS_W-1:0]          i_status,
    output logic [BITS-1:0]              o_res,
    output logic [STATUS_W-1:0]          o_status,
    output logic                         o_res_valid,
    input  logic                         i_res_ready,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int LAT_W = $clog2(LAT + 2);
    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(LAT);

    logic [BITS-1:0]            head_a;
    logic [BITS-1:0]            head_b;
    logic [1:0]                 head_op;
    logic [$clog2(DEPTH+1)-1:0] fifo_count;
    logic                       fifo_ready;
    logic                       has_cmd;
    logic                       pop_cmd;

    exe_state_e           state_q, state_d;
    logic [BITS-1:0]      a_q, a_d;
    logic [BITS-1:0]      b_q, b_d;
    exe_op_e              op_q, op_d;
    logic [LAT_W-1:0]     lat_q, lat_d;
    logic [BITS-1:0]      res_q, res_d;
    logic [STATUS_W-1:0]  status_q, status_d;
    logic                 valid_q, valid_d;

    exe_cmd_fifo #(
        .BITS  (BITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (i_valid),
        .i_a     (in_a),
        .i_b     (in_b),
        .i_op    (i_op),
        .i_pop   (pop_cmd),
        .o_a     (head_a),
        .o_b     (head_b),
        .o_op    (head_op),
        .o_count (fifo_count),
        .o_ready (fifo_ready)
    );

    assign has_cmd = (fifo_count != '0);

    // Issuing a command is shared by IDLE and by an accepted HOLD, which lets
    // results stream back-to-back without an idle cycle in between.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        lat_d    = lat_q;
        res_d    = res_q;
        status_d = status_q;
        valid_d  = valid_q;
        pop_cmd  = 1'b0;

        case (state_q)
            IDLE: begin
                pop_cmd = has_cmd;
            end
            DRIVE: begin
                if (lat_q == '0) begin
                    res_d    = i_res;
                    status_d = i_status;
                    valid_d  = 1'b1;
                    state_d  = HOLD;
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            HOLD: begin
                if (i_res_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                    pop_cmd = has_cmd;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (pop_cmd) begin
            a_d     = head_a;
            b_d     = head_b;
            op_d    = exe_op_e'(head_op);
            lat_d   = LAT_INIT;
            state_d = DRIVE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= SUB;
            lat_q    <= '0;
            res_q    <= '0;
            status_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            lat_q    <= lat_d;
            res_q    <= res_d;
            status_q <= status_d;
            valid_q  <= valid_d;
        end
    end

    assign o_ready     = fifo_ready;
    assign o_count     = fifo_count;
    assign o_a         = a_q;
    assign o_b         = b_q;
    assign o_op        = op_q;
    assign o_res       = res_q;
    assign o_status    = status_q;
    assign o_res_valid = valid_q;

endmodule

// File: tb/tb_exe_cmd_queue.sv
// Self-checking bench: exe_cmd_queue driving a behavioural exe_unit_w6 stand-in,
// compared every cycle against a queue-based reference model.
module tb_exe_cmd_queue;
    import exe_pkg::*;

    localparam int BITS  = 8;
    localparam int DEPTH = 4;
    localparam int LAT   = 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct {
        logic [BITS-1:0] a;
        logic [BITS-1:0] b;
        logic [1:0]      op;
    } cmd_t;

    logic                i_clk;
    logic                i_rst;
    logic [BITS-1:0]     in_a, in_b;
    logic [1:0]          i_op;
    logic                i_valid;
    logic                o_ready;
    logic [BITS-1:0]     o_a, o_b;
    logic [1:0]          o_op;
    logic [BITS-1:0]     i_res;
    logic [STATUS_W-1:0] i_status;
    logic [BITS-1:0]     o_res;
    logic [STATUS_W-1:0] o_status;
    logic                o_res_valid;
    logic                i_res_ready;
    logic [CNT_W-1:0]    o_count;

    int checks_total = 0;
    int checks_passed = 0;

    exe_cmd_queue #(
        .BITS  (BITS),
        .DEPTH (DEPTH),
        .LAT   (LAT)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .in_a        (in_a),
        .in_b        (in_b),
        .i_op        (i_op),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .o_a         (o_a),
        .o_b         (o_b),
        .o_op        (o_op),
        .i_res       (i_res),
        .i_status    (i_status),
        .o_res       (o_res),
        .o_status    (o_status),
        .o_res_valid (o_res_valid),
        .i_res_ready (i_res_ready),
        .o_count     (o_count)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Operation set of the execution unit; status = {zero, msb, a<b, a==b}.
    function automatic logic [BITS+STATUS_W-1:0] exe_fn(logic [BITS-1:0] a, logic [BITS-1:0] b, logic [1:0] op);
        logic [BITS-1:0] r;
        case (op)
            SUB:     r = a - b;
            CMP:     r = (a > b) ? a : b;
            SHF:     r = a << b[2:0];
            default: r = a ^ (BITS'(1) << b[2:0]);
        endcase
        return {(r == '0), r[BITS-1], (a < b), (a == b), r};
    endfunction

    logic [BITS+STATUS_W-1:0] unit_now;
    logic [BITS+STATUS_W-1:0] unit_pipe [LAT];

    assign unit_now = exe_fn(o_a, o_b, o_op);

    always @(posedge i_clk) begin
        if (!i_rst) begin
            for (int i = 0; i < LAT; i++) unit_pipe[i] <= '0;
        end else begin
            unit_pipe[0] <= unit_now;
            for (int i = 1; i < LAT; i++) unit_pipe[i] <= unit_pipe[i-1];
        end
    end

    assign {i_status, i_res} = unit_pipe[LAT-1];

    // Reference model: a plain queue of waiting commands plus the one in flight.
    cmd_t                model_q[$];
    bit                  model_live = 0;
    bit                  m_busy = 0;
    bit                  m_valid = 0;
    int                  m_wait = 0;
    logic [BITS-1:0]     m_res = '0;
    logic [STATUS_W-1:0] m_status = '0;
    logic [BITS-1:0]     m_a = '0;
    logic [BITS-1:0]     m_b = '0;
    logic [1:0]          m_op = '0;

    always @(posedge i_clk) begin
        int   pre;
        bit   can_pop;
        cmd_t c;
        if (!i_rst) begin
            model_q.delete();
            m_busy = 0; m_valid = 0; m_wait = 0;
            m_res = '0; m_status = '0; m_a = '0; m_b = '0; m_op = '0;
            model_live = 1;
        end else begin
            pre = model_q.size();
            can_pop = 0;
            if (!m_busy) begin
                can_pop = 1;
            end else if (m_valid) begin
                if (i_res_ready) begin
                    m_valid = 0;
                    m_busy = 0;
                    can_pop = 1;
                end
            end else if (m_wait == 0) begin
                {m_status, m_res} = exe_fn(m_a, m_b, m_op);
                m_valid = 1;
            end else begin
                m_wait--;
            end
            if (can_pop && pre > 0) begin
                c = model_q.pop_front();
                m_a = c.a; m_b = c.b; m_op = c.op;
                m_busy = 1;
                m_wait = LAT;
            end
            if (i_valid && pre < DEPTH) begin
                c.a = in_a; c.b = in_b; c.op = i_op;
                model_q.push_back(c);
            end
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks_total++;
        if (actual == expected) checks_passed++;
        else $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    endtask

    always @(negedge i_clk) begin
        if (model_live) begin
            checkOutput("o_count", o_count, model_q.size());
            checkOutput("o_ready", o_ready, (model_q.size() < DEPTH) ? 1 : 0);
            checkOutput("o_res_valid", o_res_valid, m_valid);
            checkOutput("o_res", o_res, m_res);
            checkOutput("o_status", o_status, m_status);
            checkOutput("o_a", o_a, m_a);
            checkOutput("o_b", o_b, m_b);
            checkOutput("o_op", o_op, m_op);
        end
    end

    task automatic applyStimulus(input logic v, input logic [BITS-1:0] a, input logic [BITS-1:0] b,
                                 input logic [1:0] op, input logic rr);
        i_valid     = v;
        in_a        = a;
        in_b        = b;
        i_op        = op;
        i_res_ready = rr;
        @(posedge i_clk);
        #2;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: time limit reached, got running, expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [BITS-1:0] got[$];
        int exp_res[5];

        i_rst = 1'b0;
        i_valid = 1'b0; in_a = '0; in_b = '0; i_op = '0; i_res_ready = 1'b0;
        repeat (3) applyStimulus(0, 0, 0, SUB, 0);
        checkOutput("reset_count", o_count, 0);
        checkOutput("reset_ready", o_ready, 1);
        checkOutput("reset_valid", o_res_valid, 0);
        i_rst = 1'b1;

        // Single SUB: first push right after reset release, result LAT+1 after pop.
        applyStimulus(1, 91, 41, SUB, 1);
        checkOutput("t1_count_after_push", o_count, 1);
        applyStimulus(0, 0, 0, SUB, 1);
        checkOutput("t1_popped_a", o_a, 91);
        checkOutput("t1_count_after_pop", o_count, 0);
        for (int k = 0; k < LAT; k++) begin
            applyStimulus(0, 0, 0, SUB, 1);
            checkOutput("t1_valid_early", o_res_valid, 0);
        end
        applyStimulus(0, 0, 0, SUB, 1);
        checkOutput("t1_valid", o_res_valid, 1);
        checkOutput("t1_res", o_res, 50);
        checkOutput("t1_status", o_status, 0);
        applyStimulus(0, 0, 0, SUB, 1);
        checkOutput("t1_valid_cleared", o_res_valid, 0);

        // Fill the queue while the result is stalled; extra push must be dropped.
        applyStimulus(1, 10, 3, SUB, 0);
        applyStimulus(1, 20, 5, SUB, 0);
        applyStimulus(1, 30, 7, SUB, 0);
        applyStimulus(1, 40, 9, SUB, 0);
        applyStimulus(1, 50, 11, SUB, 0);
        checkOutput("t2_full_count", o_count, 4);
        checkOutput("t2_full_ready", o_ready, 0);
        applyStimulus(1, 99, 1, SUB, 0);
        checkOutput("t2_ignored_push_count", o_count, 4);
        exp_res = '{7, 15, 23, 31, 39};
        for (int k = 0; k < 40 && got.size() < 5; k++) begin
            if (o_res_valid) got.push_back(o_res);
            applyStimulus(0, 0, 0, SUB, 1);
        end
        checkOutput("t2_result_count", got.size(), 5);
        for (int k = 0; k < 5; k++)
            checkOutput("t2_result_order", (k < got.size()) ? int'(got[k]) : -1, exp_res[k]);
        repeat (3) applyStimulus(0, 0, 0, SUB, 1);

        // Stalled HOLD stays stable; then push and pop together at count 2.
        applyStimulus(1, 5, 9, CMP, 0);
        applyStimulus(1, 6, 2, SUB, 0);
        applyStimulus(1, 7, 3, SUB, 0);
        applyStimulus(0, 0, 0, SUB, 0);
        checkOutput("t3_count", o_count, 2);
        for (int k = 0; k < 5; k++) begin
            checkOutput("t3_hold_valid", o_res_valid, 1);
            checkOutput("t3_hold_res", o_res, 9);
            checkOutput("t3_hold_status", o_status, 2);
            applyStimulus(0, 0, 0, SUB, 0);
        end
        applyStimulus(1, 9, 9, SUB, 1);
        checkOutput("t3_push_pop_count", o_count, 2);
        checkOutput("t3_next_a", o_a, 6);
        repeat (20) applyStimulus(0, 0, 0, SUB, 1);

        // Reset while a command is in flight with three more queued.
        for (int k = 1; k <= 5; k++) applyStimulus(1, BITS'(k), 1, SUB, 0);
        applyStimulus(0, 0, 0, SUB, 1);
        checkOutput("t4_queued_before_reset", o_count, 3);
        i_rst = 1'b0;
        repeat (2) applyStimulus(0, 0, 0, SUB, 1);
        i_rst = 1'b1;
        checkOutput("t4_count_after_reset", o_count, 0);
        checkOutput("t4_valid_after_reset", o_res_valid, 0);
        checkOutput("t4_ready_after_reset", o_ready, 1);
        for (int k = 0; k < 8; k++) begin
            applyStimulus(0, 0, 0, SUB, 1);
            checkOutput("t4_no_stale_result", o_res_valid, 0);
        end

        // Random traffic with occasional resets, checked by the model each cycle.
        for (int k = 0; k < 3000; k++) begin
            i_rst = ($urandom_range(0, 299) != 0);
            applyStimulus(($urandom_range(0, 2) != 0), BITS'($urandom), BITS'($urandom),
                          2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0));
        end
        i_rst = 1'b1;
        repeat (2) applyStimulus(0, 0, 0, SUB, 1);

        $display("[TB] %0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
